// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enumeration, default datapath width and the flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_XOR = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOR = 3'd4,
    OP_SL  = 3'd5,
    OP_SR  = 3'd6,
    OP_SUB = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic neg;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// ALU request/result bus. The master drives operands; the slave (alu_core) returns result and flags.
interface alu_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Alu_out;
  logic             out_valid;
  logic             overflow;
  logic             zero;
  logic             neg;
  logic             carry;

  modport master (
    output in_valid, opcode, A, B,
    input  Alu_out, out_valid, overflow, zero, neg, carry
  );

  modport slave (
    input  in_valid, opcode, A, B,
    output Alu_out, out_valid, overflow, zero, neg, carry
  );
endinterface

// File: rtl/alu_shifter.sv
// Combinational logical shifter for SL/SR; carry is the last bit shifted out (0 for a zero shift).
module alu_shifter import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir_right,
  output logic [WIDTH-1:0] res,
  output logic             carry
);
  logic [WIDTH:0] lft;
  logic [WIDTH:0] rgt;

  // One guard bit on each side catches the last bit shifted out.
  always_comb begin
    lft   = {1'b0, a} << shamt;
    rgt   = {a, 1'b0} >> shamt;
    res   = dir_right ? rgt[WIDTH:1] : lft[WIDTH-1:0];
    carry = dir_right ? rgt[0]       : lft[WIDTH];
  end
endmodule

// File: rtl/alu_core.sv
// Single-stage registered ALU with status flags. Define ALU_BARREL_SHIFT_EN to shift
// SL/SR by B[log2(WIDTH)-1:0]; otherwise SL/SR are fixed 1-bit shifts.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic  clk,
  input logic  reset,
  alu_if.slave bus
);
  localparam int SHW    = $clog2(WIDTH);
  localparam int STAGES = 1;

  alu_op_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sh_res;
  logic             sh_carry;
  logic [WIDTH-1:0] res;
  alu_flags_t       flg;

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flg_q;

  assign op = alu_op_e'(bus.opcode);

`ifdef ALU_BARREL_SHIFT_EN
  assign shamt = bus.B[SHW-1:0];
`else
  assign shamt = SHW'(1);
`endif

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a         (bus.A),
    .shamt     (shamt),
    .dir_right (op == OP_SR),
    .res       (sh_res),
    .carry     (sh_carry)
  );

  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  // diff[WIDTH] is the borrow, so carry on SUB is its inverse (A >= B unsigned).
  assign diff = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    res = '0;
    flg = '0;
    unique case (op)
      OP_ADD: begin
        res          = sum[WIDTH-1:0];
        flg.carry    = sum[WIDTH];
        flg.overflow = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res          = diff[WIDTH-1:0];
        flg.carry    = ~diff[WIDTH];
        flg.overflow = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_XOR: res = bus.A ^ bus.B;
      OP_AND: res = bus.A & bus.B;
      OP_OR:  res = bus.A | bus.B;
      OP_NOR: res = ~(bus.A | bus.B);
      OP_SL, OP_SR: begin
        res       = sh_res;
        flg.carry = sh_carry;
      end
    endcase
    flg.zero = (res == '0);
    flg.neg  = res[WIDTH-1];
  end

  // Reset wins over in_valid, so an op presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      vld_pipe <= bus.in_valid;
      if (bus.in_valid) begin
        res_q <= res;
        flg_q <= flg;
      end
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.Alu_out   = res_q;
  assign bus.overflow  = flg_q.overflow;
  assign bus.zero      = flg_q.zero;
  assign bus.neg       = flg_q.neg;
  assign bus.carry     = flg_q.carry;
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected results queued at drive time, popped when out_valid rises.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [3:0]   flg;   // {overflow, zero, neg, carry}
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vld_seen = 1'b0;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  logic [W-1:0] last_res;
  logic [3:0]   last_flg;

  alu_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_, s;
    int     sh;
    logic   c, v;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
`ifdef ALU_BARREL_SHIFT_EN
    sh = int'(b[4:0]);
`else
    sh = 1;
`endif
    case (op)
      3'd0: begin
        r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        s = sa + sb_;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: r = a ^ b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~(a | b);
      3'd5: begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[W-sh];
      end
      3'd6: begin
        r = a >> sh;
        c = (sh == 0) ? 1'b0 : a[sh-1];
      end
      default: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb_;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    e.tag = "";
    e.res = r;
    e.flg = {v, (r == '0), r[W-1], c};
    return e;
  endfunction

  task automatic drive(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.A        = a;
    bus.B        = b;
    e = model(op, a, b);
    e.tag = tag;
    sb.push_back(e);
    last_res = e.res;
    last_flg = e.flg;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  always @(posedge clk) vld_seen <= bus.in_valid && !reset;

  // Monitor: out_valid must track accepted inputs with one-cycle latency.
  always @(negedge clk) begin
    exp_t e;
    check("out_valid", 64'(bus.out_valid), 64'(vld_seen));
    if (bus.out_valid === 1'b1) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, "_res"}, 64'(bus.Alu_out), 64'(e.res));
        check({e.tag, "_flags"}, 64'({bus.overflow, bus.zero, bus.neg, bus.carry}), 64'(e.flg));
      end
    end
  end

  logic [W-1:0] specials [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h5555_AAAA};

  initial begin
    logic [W-1:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.A        = '0;
    bus.B        = '0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res",   64'(bus.Alu_out), 64'(0));
    check("rst_flags", 64'({bus.overflow, bus.zero, bus.neg, bus.carry}), 64'(0));
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    reset = 1'b0;

    drive("add_5_10",  3'd0, 32'd5, 32'd10);
    idle();
    drive("xor",       3'd1, 32'd26, 32'd17);
    drive("and",       3'd2, 32'd100, 32'd900);
    drive("or",        3'd3, 32'd36, 32'd79);
    drive("nor",       3'd4, 32'd46, 32'd200);
    drive("sl_128",    3'd5, 32'd128, 32'd1);
    drive("sr_256",    3'd6, 32'd256, 32'd1);
    drive("sl_msb",    3'd5, 32'h8000_0000, 32'd1);
    drive("sub_67_55", 3'd7, 32'd67, 32'd55);
    drive("sub_5_5",   3'd7, 32'd5, 32'd5);
    drive("sub_0_1",   3'd7, 32'd0, 32'd1);
    drive("add_ovf",   3'd0, 32'h7FFF_FFFF, 32'd1);
    drive("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'd1);

    // Outputs must hold while in_valid is low even as operands change.
    idle();
    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'h1234_5678;
    @(posedge clk); #1;
    check("hold_res",   64'(bus.Alu_out), 64'(last_res));
    check("hold_flags", 64'({bus.overflow, bus.zero, bus.neg, bus.carry}), 64'(last_flg));
    check("hold_valid", 64'(bus.out_valid), 64'(0));

    // An op presented with reset is dropped and the registers clear.
    drive("pre_rst", 3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.opcode   = 3'd0;
    bus.A        = 32'd9;
    bus.B        = 32'd9;
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("rstv_res",   64'(bus.Alu_out), 64'(0));
    check("rstv_flags", 64'({bus.overflow, bus.zero, bus.neg, bus.carry}), 64'(0));
    check("rstv_valid", 64'(bus.out_valid), 64'(0));

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
      drive($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, rb);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port: reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: in_valid  input  1  operands and opcode valid this cycle.
REQ-005 SHALL have port: opcode  input  3  operation select.
REQ-006 SHALL have port: A  input  WIDTH  first operand.
REQ-007 SHALL have port: B  input  WIDTH  second operand.
REQ-008 SHALL have port: Alu_out  output  WIDTH  registered result.
REQ-009 SHALL have port: out_valid  output  1  Alu_out and flags hold a new result.
REQ-010 SHALL have ports: overflow, zero, neg, carry  output  1 each  registered status flags.

Function
REQ-011 SHALL decode opcode: 0 ADD A+B; 1 XOR; 2 AND; 3 OR; 4 NOR ~(A|B); 5 SL logical left; 6 SR logical right; 7 SUB A-B.
REQ-012 SHALL shift the operand A by exactly 1 bit for SL/SR, ignoring B, zero-filling, unless the REQ-021 macro is defined.
REQ-013 SHALL compute all arithmetic modulo 2^WIDTH, with results truncated to WIDTH bits.
REQ-014 SHALL set carry: ADD = carry-out of bit WIDTH-1; SUB = 1 when A >= B unsigned (no borrow); SL = old A[WIDTH-1]; SR = old A[0]; logic ops = 0.
REQ-015 SHALL set overflow on two's-complement signed overflow for ADD/SUB only; 0 for all other ops.
REQ-016 SHALL set zero = (result == 0), and neg = result[WIDTH-1], for every opcode.
REQ-017 SHALL register the result and flags on the rising edge when in_valid=1, with 1-cycle latency, and set out_valid=1 in the following cycle.
REQ-018 SHALL hold Alu_out and the flags when in_valid=0, and drive out_valid=0 in that case; the block SHALL have no backpressure and SHALL accept back-to-back inputs every cycle.

Reset
REQ-019 SHALL clear Alu_out, all flags and out_valid to 0 on a clock edge with reset=1; reset SHALL take priority over in_valid.
REQ-020 SHALL discard an operation presented in the same cycle as reset, with no output produced for it.

Configuration
REQ-021 SHALL, when macro ALU_BARREL_SHIFT_EN is defined, shift by B[log2(WIDTH)-1:0] for SL/SR; a shift amount of 0 SHALL pass A through with carry=0, otherwise carry = last bit shifted out. When the macro is undefined, SL/SR SHALL be fixed 1-bit shifts per REQ-012.

Structure
REQ-022 SHALL place the opcode enumeration (ADD..SUB, 3-bit) and the WIDTH default in shared package alu_pkg.
REQ-023 SHALL use one combinational sub-module alu_shifter for SL/SR and the shift carry; everything else SHALL be in alu_core.

Verification
REQ-024 SHALL cover: ADD A=5,B=10 -> Alu_out=15, zero=0, neg=0, carry=0, overflow=0, with out_valid one cycle later.
REQ-025 SHALL cover logic ops: XOR 26,17 -> 11; AND 100,900 -> 4; OR 36,79 -> 111; NOR 46,200 -> 0xFFFFFF11 with neg=1.
REQ-026 SHALL cover shifts with the macro undefined: SL A=128 -> 256; SR A=256 -> 128; SL A=0x80000000 -> 0 with zero=1, carry=1.
REQ-027 SHALL cover SUB: 67-55 -> 12 with carry=1; 5-5 -> 0 with zero=1; 0-1 -> 0xFFFFFFFF with carry=0, neg=1.
REQ-028 SHALL cover overflow: ADD 0x7FFFFFFF+1 -> 0x80000000 with overflow=1, neg=1; ADD 0xFFFFFFFF+1 -> 0 with carry=1, zero=1, overflow=0.
REQ-029 SHALL cover reset asserted with in_valid=1 -> all outputs 0 next cycle; in_valid=0 after a result -> outputs hold and out_valid=0.
